sevenseg_capture: RTL and testbench
===================================

# sevenseg_capture

Receive-side counterpart to the seven-segment display driver: monitors the multiplexed active-low anode/segment/decimal-point lines and reconstructs the eight displayed digit codes and decimal points. It sits beside the display driver on the Nexys4 top level and in the testbench. There it provides self-checking of the digits actually scanned out, and flags scan faults such as multiple active anodes, unknown segment patterns or a stalled refresh.

## Interface
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured (≥1).
- TIMEOUT_CYCLES, 1000000: clocks without any capture before all valid bits clear (10 ms at 100 MHz).
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- an  input  8  anodes, active-low; an[n] selects digit n.
- seg  input  7  segments, active-low, {g,f,e,d,c,b,a}.
- dp  input  1  decimal point, active-low.
- clr_err  input  1  synchronous one-cycle clear of sticky error flags.
- d0..d7  output  5 each  captured digit codes.
- decpts  output  8  captured decimal points, active-high; decpts[n] for digit n.
- digit_valid  output  8  digit n captured since reset or last timeout.
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured.
- multi_err  output  1  sticky: ≥2 anodes active and stable.
- pat_err  output  1  sticky: unknown segment pattern captured.
- digits_out  output  64  ASCII image; present only with SEVENSEG_CAPTURE_ASCII_EN.

## Operation
- Input register: {an, seg, dp} sampled every clk and compared with the previous sample; a stability counter saturates at SETTLE_CYCLES.
- FSM states:
  - IDLE: all anodes high, or sample changed. Entered on any change.
  - SETTLE: exactly one anode low and counting.
  - HOLD: captured; waits for a change.
  - SETTLE→HOLD: the count reaches SETTLE_CYCLES. The digit is written; further identical samples do not rewrite it.
  - ≥2 anodes low for SETTLE_CYCLES samples sets multi_err. No capture occurs; FSM goes to HOLD.
- Decode, active-low seg to code:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10. Resulting codes 0x00–0x09.
  - A:08, b:03, C:46, d:21, E:06, F:0E. Resulting codes 0x0A–0x0F.
  - 7F (blank) → code 0x1F.
  - Any other pattern → code 0x1E and sets pat_err.
- On capture of digit n: d<n>←code, decpts[n]←~dp, digit_valid[n]←1, seen[n]←1.
- frame_done: asserted when seen becomes 8'hFF; seen clears to 0 on the same edge.
- Timeout counter: reloads on every capture. At TIMEOUT_CYCLES it clears digit_valid and seen; d*/decpts are retained. If a capture and the timeout fall in the same cycle, the capture wins.
- clr_err and a new error in the same cycle: the error flag is set (set wins).
- Reset values: d0..d7=5'h1F, decpts=0, digit_valid=0, frame_done=0, multi_err=0, pat_err=0, digits_out=all 0x20, FSM=IDLE, counters=0.
- Reset assertion mid-settle or mid-frame discards all partial state immediately.

## Timing
- Input change to d<n>/decpts/digit_valid update: SETTLE_CYCLES+1 clocks.
- frame_done: one cycle high, on the same edge as the eighth distinct capture.
- Error flags: set on the same edge the capture or multi-anode decision would occur.
- Glitches shorter than SETTLE_CYCLES samples are never captured.
- TIMEOUT_CYCLES is counted from the edge of the last capture. Counter width is clog2(TIMEOUT_CYCLES+1).

## Configuration
- SEVENSEG_CAPTURE_ASCII_EN defined:
  - digits_out[63:0] present and registered together with d*.
  - Byte 7 (bits 63:56) corresponds to digit 7.
  - Codes 0x00–0x09 → '0'–'9', 0x0A–0x0F → 'A'–'F', 0x1F → 0x20, 0x1E → '?' (0x3F).
- SEVENSEG_CAPTURE_ASCII_EN undefined: digits_out port and logic absent; all other behaviour identical.

## Test plan
- Capture latency: an=8'hFE, seg=7'h30, dp=1 held, SETTLE_CYCLES=4. Expect d0=0x03, decpts[0]=0, digit_valid=8'h01 exactly 5 clocks later, and not earlier.
- Full frame: scan digits 0..7 with patterns for 0–7, dp low on digit 2, 100 clocks per digit. Expect frame_done pulsing once per scan, d0..d7=0..7, decpts=8'h04, ASCII "76543210" when the macro is defined.
- Faults: an=8'hFC stable 10 clocks, expect multi_err=1 and no d* change. Then seg=7'h55 on digit 1, expect d1=0x1E and pat_err=1. clr_err pulse clears both; clr_err coincident with a new pat_err leaves pat_err=1.
- Glitch rejection: a 3-clock pattern 7'h79 on digit 4 between stable blanks. Expect d4 to remain 0x1F.
- Timeout: stop scanning with all anodes high, TIMEOUT_CYCLES=1000. Expect digit_valid=0 after 1000 clocks and d* values retained. A capture in the timeout cycle keeps its valid bit set.
- Reset: assert reset mid-SETTLE and mid-frame. Expect all outputs at reset values asynchronously, and no frame_done after release until 8 new captures.

Source files
------------

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: rebuilds the eight digit codes and decimal points from multiplexed active-low
// seven-segment scan lines and flags scan faults; SEVENSEG_CAPTURE_ASCII_EN adds the digits_out ASCII image.
module sevenseg_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic       clr_err,
    output logic [4:0] d0,
    output logic [4:0] d1,
    output logic [4:0] d2,
    output logic [4:0] d3,
    output logic [4:0] d4,
    output logic [4:0] d5,
    output logic [4:0] d6,
    output logic [4:0] d7,
    output logic [7:0] decpts,
    output logic [7:0] digit_valid,
    output logic       frame_done,
    output logic       multi_err,
    output logic       pat_err
`ifdef SEVENSEG_CAPTURE_ASCII_EN
    ,
    output logic [63:0] digits_out
`endif
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: return 5'h00;
            7'h79: return 5'h01;
            7'h24: return 5'h02;
            7'h30: return 5'h03;
            7'h19: return 5'h04;
            7'h12: return 5'h05;
            7'h02: return 5'h06;
            7'h78: return 5'h07;
            7'h00: return 5'h08;
            7'h10: return 5'h09;
            7'h08: return 5'h0A;
            7'h03: return 5'h0B;
            7'h46: return 5'h0C;
            7'h21: return 5'h0D;
            7'h06: return 5'h0E;
            7'h0E: return 5'h0F;
            7'h7F: return 5'h1F;
            default: return 5'h1E;
        endcase
    endfunction

    logic [15:0]   samp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [4:0]    dig_q [8];
    logic [7:0]    dp_q, valid_q, valid_d, seen_q, seen_d, low, merged;
    logic [4:0]    code;
    logic          fd_q, multi_q, pat_q;
    logic          same, any_low, one_low, ready, cap, multi_set, frame, timeout;

    always_comb begin
        low       = ~an;
        same      = {an, seg, dp} == samp_q;
        any_low   = |low;
        one_low   = any_low && ((low & (low - 8'd1)) == 8'd0);
        // the decision is taken exactly once per stable sample run; HOLD blocks rewrites
        ready     = same && state_q != HOLD && cnt_q == CW'(SETTLE_CYCLES - 1);
        cap       = ready && one_low;
        multi_set = ready && any_low && !one_low;
        code      = decode(seg);
        cnt_d     = !same ? '0 : cnt_q == CW'(SETTLE_CYCLES) ? cnt_q : cnt_q + CW'(1);
        state_d   = (!same || !any_low) ? IDLE : (state_q == HOLD || ready) ? HOLD : SETTLE;
        // a capture reloads the timeout counter, so it pre-empts a coincident timeout
        timeout   = !cap && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
        tcnt_d    = cap ? '0 : tcnt_q == TW'(TIMEOUT_CYCLES) ? tcnt_q : tcnt_q + TW'(1);
        merged    = seen_q | low;
        frame     = cap && merged == 8'hFF;
        seen_d    = (timeout || frame) ? '0 : cap ? merged : seen_q;
        valid_d   = timeout ? '0 : cap ? valid_q | low : valid_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q  <= '1;
            cnt_q   <= '0;
            state_q <= IDLE;
            tcnt_q  <= '0;
            dp_q    <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            fd_q    <= 1'b0;
            multi_q <= 1'b0;
            pat_q   <= 1'b0;
            for (int i = 0; i < 8; i++) dig_q[i] <= 5'h1F;
        end else begin
            samp_q  <= {an, seg, dp};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            fd_q    <= frame;
            multi_q <= (multi_q && !clr_err) || multi_set;
            pat_q   <= (pat_q && !clr_err) || (cap && code == 5'h1E);
            for (int i = 0; i < 8; i++) begin
                if (cap && low[i]) begin
                    dig_q[i] <= code;
                    dp_q[i]  <= ~dp;
                end
            end
        end
    end

    assign d0          = dig_q[0];
    assign d1          = dig_q[1];
    assign d2          = dig_q[2];
    assign d3          = dig_q[3];
    assign d4          = dig_q[4];
    assign d5          = dig_q[5];
    assign d6          = dig_q[6];
    assign d7          = dig_q[7];
    assign decpts      = dp_q;
    assign digit_valid = valid_q;
    assign frame_done  = fd_q;
    assign multi_err   = multi_q;
    assign pat_err     = pat_q;

`ifdef SEVENSEG_CAPTURE_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [4:0] c);
        return c < 5'd10 ? 8'h30 + {3'b0, c} : c < 5'h10 ? 8'h37 + {3'b0, c} : c == 5'h1F ? 8'h20 : 8'h3F;
    endfunction

    logic [63:0] asc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asc_q <= {8{8'h20}};
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cap && low[i]) asc_q[i*8 +: 8] <= to_ascii(code);
            end
        end
    end

    assign digits_out = asc_q;
`endif
endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: randomized and directed checks of sevenseg_capture against a cycle-level model
// built from the digit capture rules (sample runs, decode table, frame and timeout bookkeeping).
module tb_sevenseg_capture;
    localparam int S = 4;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] an = 8'hFF;
    logic [6:0] seg = 7'h7F;
    logic       dp = 1'b1;
    logic       clr_err = 1'b0;
    logic [4:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0] decpts, digit_valid;
    logic       frame_done, multi_err, pat_err;
`ifdef SEVENSEG_CAPTURE_ASCII_EN
    logic [63:0] digits_out;
`endif

    sevenseg_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp), .clr_err(clr_err),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .decpts(decpts), .digit_valid(digit_valid), .frame_done(frame_done),
        .multi_err(multi_err), .pat_err(pat_err)
`ifdef SEVENSEG_CAPTURE_ASCII_EN
        , .digits_out(digits_out)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [4:0]  exp_d [8];
    logic [7:0]  exp_dp, exp_valid, exp_seen;
    logic        exp_fd, exp_multi, exp_pat;
    logic [15:0] last;
    int          run, since;

    wire [39:0] dut_digits = {d7, d6, d5, d4, d3, d2, d1, d0};
    wire [58:0] dut_vec = {frame_done, digit_valid, decpts, multi_err, pat_err, dut_digits};

    function automatic logic [58:0] exp_vec();
        return {exp_fd, exp_valid, exp_dp, exp_multi, exp_pat,
                exp_d[7], exp_d[6], exp_d[5], exp_d[4], exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
    endfunction

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        if (s == 7'h7F) return 5'h1F;
        for (int i = 0; i < 16; i++) if (pats[i] == s) return 5'(i);
        return 5'h1E;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_d[i] = 5'h1F;
        exp_dp = 0; exp_valid = 0; exp_seen = 0;
        exp_fd = 0; exp_multi = 0; exp_pat = 0;
        last = 16'hFFFF; run = 0; since = 0;
    endtask

    // one clock of the capture rules, applied to the inputs present at the rising edge
    task automatic model_tick();
        logic captured;
        captured = 1'b0;
        exp_fd = 1'b0;
        if (clr_err) begin exp_multi = 0; exp_pat = 0; end
        if ({an, seg, dp} != last) begin
            last = {an, seg, dp};
            run = 0;
        end else if (run < S) begin
            run++;
            if (run == S && 8 - $countones(an) >= 2) exp_multi = 1;
            if (run == S && 8 - $countones(an) == 1) begin
                captured = 1'b1;
                for (int n = 0; n < 8; n++) begin
                    if (!an[n]) begin
                        exp_d[n] = model_decode(seg);
                        exp_dp[n] = ~dp;
                        exp_valid[n] = 1;
                        exp_seen[n] = 1;
                    end
                end
                if (model_decode(seg) == 5'h1E) exp_pat = 1;
                if (exp_seen == 8'hFF) begin exp_fd = 1; exp_seen = 0; end
            end
        end
        if (captured) since = 0;
        else if (since < T) begin
            since++;
            if (since == T) begin exp_valid = 0; exp_seen = 0; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic p);
        an = a; seg = s; dp = p;
    endtask

    task automatic test_reset();
        @(negedge clk);
        model_reset();
        vectors++;
        if (dut_vec !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, {8{5'h1F}}}) begin
            errors++; $display("FAIL reset_in: got %h required %h", dut_vec, exp_vec());
        end
        reset = 1'b1;
        repeat (3) step();
        vectors++;
        if (dut_vec !== exp_vec() || digit_valid !== 8'h00 || dut_digits !== {8{5'h1F}}) begin
            errors++; $display("FAIL reset_out: got %h required %h", dut_vec, exp_vec());
        end
`ifdef SEVENSEG_CAPTURE_ASCII_EN
        vectors++;
        if (digits_out !== {8{8'h20}}) begin
            errors++; $display("FAIL reset_ascii: got %h required %h", digits_out, {8{8'h20}});
        end
`endif
    endtask

    task automatic test_glitch();
        drive(8'hFF, 7'h7F, 1'b1);
        repeat (10) step();
        drive(8'hEF, 7'h79, 1'b1);
        repeat (3) step();
        drive(8'hFF, 7'h7F, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL glitch cyc%0d: got %h required %h", k, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (d4 !== 5'h1F || digit_valid !== 8'h00) begin
            errors++; $display("FAIL glitch_d4: got d4=%h valid=%h required 1f/00", d4, digit_valid);
        end
    endtask

    task automatic test_latency();
        drive(8'hFE, 7'h30, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL latency cyc%0d: got %h required %h", k, dut_vec, exp_vec());
            end
            if (k == 4) begin
                vectors++;
                if (digit_valid !== 8'h00) begin
                    errors++; $display("FAIL latency_early: got valid=%h required 00", digit_valid);
                end
            end
            if (k == 5) begin
                vectors++;
                if (d0 !== 5'h03 || decpts[0] !== 1'b0 || digit_valid !== 8'h01) begin
                    errors++; $display("FAIL latency_at5: got d0=%h dp=%b valid=%h required 03/0/01", d0, decpts[0], digit_valid);
                end
            end
        end
    endtask

    task automatic test_frame();
        int pulses;
        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 8; n++) begin
                drive(~(8'd1 << n), pats[n], n != 2);
                for (int k = 0; k < 100; k++) begin
                    step();
                    pulses += int'(frame_done);
                    vectors++;
                    if (dut_vec !== exp_vec()) begin
                        errors++; $display("FAIL frame s%0d d%0d c%0d: got %h required %h", f, n, k, dut_vec, exp_vec());
                    end
                end
            end
        end
        vectors++;
        if (pulses !== 2) begin
            errors++; $display("FAIL frame_pulses: got %0d required 2", pulses);
        end
        vectors++;
        if (dut_digits !== {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0} || decpts !== 8'h04) begin
            errors++; $display("FAIL frame_digits: got %h dp=%h required 0..7 dp=04", dut_digits, decpts);
        end
`ifdef SEVENSEG_CAPTURE_ASCII_EN
        vectors++;
        if (digits_out !== 64'h3736353433323130) begin
            errors++; $display("FAIL frame_ascii: got %h required 3736353433323130", digits_out);
        end
`endif
    endtask

    task automatic test_faults();
        drive(8'hFC, 7'h40, 1'b1);
        repeat (10) step();
        vectors++;
        if (multi_err !== 1'b1 || dut_digits !== {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}) begin
            errors++; $display("FAIL multi: got err=%b digits=%h required 1 and 0..7", multi_err, dut_digits);
        end
        drive(8'hFD, 7'h55, 1'b1);
        repeat (6) step();
        vectors++;
        if (d1 !== 5'h1E || pat_err !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL pattern: got d1=%h pat=%b required 1e/1", d1, pat_err);
        end
        drive(8'hFF, 7'h7F, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        step();
        vectors++;
        if (multi_err !== 1'b0 || pat_err !== 1'b0) begin
            errors++; $display("FAIL clr_err: got multi=%b pat=%b required 0/0", multi_err, pat_err);
        end
        drive(8'hF7, 7'h55, 1'b1);
        repeat (4) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        vectors++;
        if (pat_err !== 1'b1 || d3 !== 5'h1E || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL set_wins: got pat=%b d3=%h required 1/1e", pat_err, d3);
        end
    endtask

    task automatic test_random();
        int r, len;
        logic [7:0] a;
        logic [6:0] s;
        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 9);
            a = r < 7 ? ~(8'd1 << $urandom_range(0, 7)) : r < 8 ? 8'hFF : ~(8'd3 << $urandom_range(0, 6));
            r = $urandom_range(0, 9);
            s = r < 8 ? pats[$urandom_range(0, 15)] : r == 8 ? 7'h7F : 7'($urandom);
            drive(a, s, 1'($urandom));
            clr_err = $urandom_range(0, 7) == 0;
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                step();
                clr_err = 1'b0;
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random h%0d c%0d: got %h required %h", i, k, dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_timeout();
        drive(8'hFF, 7'h7F, 1'b1);
        repeat (10) step();
        drive(8'hFE, 7'h40, 1'b1);
        repeat (5) step();
        drive(8'hFF, 7'h7F, 1'b1);
        repeat (995) step();
        drive(8'hFD, 7'h79, 1'b1);
        repeat (5) step();
        vectors++;
        if (digit_valid[1] !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL timeout_coincide: got %h required %h", dut_vec, exp_vec());
        end
        drive(8'hFF, 7'h7F, 1'b1);
        for (int k = 1; k <= 1000; k++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL timeout c%0d: got %h required %h", k, dut_vec, exp_vec());
            end
            if (k == 999) begin
                vectors++;
                if (digit_valid[1:0] !== 2'b11) begin
                    errors++; $display("FAIL timeout_early: got valid=%h required bits 1:0 set", digit_valid);
                end
            end
        end
        vectors++;
        if (digit_valid !== 8'h00 || d0 !== 5'h00 || d1 !== 5'h01) begin
            errors++; $display("FAIL timeout_end: got valid=%h d0=%h d1=%h required 00/00/01", digit_valid, d0, d1);
        end
    endtask

    task automatic test_reset_mid();
        int pulses, early;
        drive(8'hFB, 7'h24, 1'b1);
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, {8{5'h1F}}}) begin
            errors++; $display("FAIL reset_settle: got %h required %h", dut_vec, exp_vec());
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(~(8'd1 << n), pats[n + 8], 1'b0);
            repeat (30) step();
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, {8{5'h1F}}}) begin
            errors++; $display("FAIL reset_frame: got %h required %h", dut_vec, exp_vec());
        end
`ifdef SEVENSEG_CAPTURE_ASCII_EN
        vectors++;
        if (digits_out !== {8{8'h20}}) begin
            errors++; $display("FAIL reset_frame_ascii: got %h required %h", digits_out, {8{8'h20}});
        end
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        early = 0;
        for (int n = 0; n < 8; n++) begin
            drive(~(8'd1 << n), pats[15 - n], 1'b1);
            for (int k = 0; k < 20; k++) begin
                step();
                pulses += int'(frame_done);
                if (n < 7) early += int'(frame_done);
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL after_reset d%0d c%0d: got %h required %h", n, k, dut_vec, exp_vec());
                end
            end
        end
        vectors++;
        if (pulses !== 1 || early !== 0) begin
            errors++; $display("FAIL after_reset_frame: got %0d pulses (%0d early) required 1 (0 early)", pulses, early);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_frame();
        test_faults();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
